// File: rtl/cache_mem_arbiter_if.sv
// Signal bundle between the two caches, the shared memory port and the arbiter.
// The arbiter takes the slave view; the caches and memory together take the master view.
interface cache_mem_arbiter_if;
    // Instruction cache side
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;

    // Data cache side
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    // Shared memory port
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic        ram_ready;

    logic        busy;

    modport slave (
        input  iREN, iaddr,
        output iload, iwait,
        input  dREN, dWEN, daddr, dstore,
        output dload, dwait,
        output ram_ren, ram_wen, ram_addr, ram_store,
        input  ram_load, ram_ready,
        output busy
    );

    modport master (
        output iREN, iaddr,
        input  iload, iwait,
        output dREN, dWEN, daddr, dstore,
        input  dload, dwait,
        input  ram_ren, ram_wen, ram_addr, ram_store,
        output ram_load, ram_ready,
        input  busy
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Grants the single memory port to the instruction or data cache, data first,
// with a starvation counter that forces an instruction grant after STARVE_LIMIT data completions.
module cache_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                CLK,
    input  logic                nRST,
    cache_mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISERVE = 2'd1,
        DSERVE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             d_req;

    assign d_req = bus.dREN | bus.dWEN;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.iREN) starve_cnt <= '0;

                    if (bus.iREN && starve_cnt == LIMIT) state <= ISERVE;
                    else if (d_req)                      state <= DSERVE;
                    else if (bus.iREN)                   state <= ISERVE;
                    else                                 state <= IDLE;
                end

                ISERVE: begin
                    if (bus.ram_ready) begin
                        state      <= IDLE;
                        starve_cnt <= '0;
                    end else if (!bus.iREN) begin
                        state <= IDLE;
                    end
                end

                DSERVE: begin
                    if (bus.ram_ready) begin
                        state <= IDLE;
                        if (bus.iREN && starve_cnt != LIMIT)
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (!d_req) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);

    // Completion is combinational on ram_ready so the wait drops in the very
    // cycle memory finishes; a dropped request kills the strobes immediately.
    // NOTE: every output gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        bus.ram_ren   = 1'b0;
        bus.ram_wen   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_store = '0;
        bus.iwait     = 1'b1;
        bus.dwait     = 1'b1;
        bus.iload     = '0;
        bus.dload     = '0;

        case (state)
            ISERVE: begin
                bus.ram_addr = bus.iaddr;
                if (bus.iREN || bus.ram_ready) bus.ram_ren = 1'b1;
                if (bus.ram_ready) begin
                    bus.iwait = 1'b0;
                    bus.iload = bus.ram_load;
                end
            end

            DSERVE: begin
                bus.ram_addr = bus.daddr;
                if (d_req || bus.ram_ready) begin
                    if (bus.dWEN) begin
                        bus.ram_wen   = 1'b1;
                        bus.ram_store = bus.dstore;
                    end else begin
                        bus.ram_ren = 1'b1;
                    end
                end
                if (bus.ram_ready) begin
                    bus.dwait = 1'b0;
                    if (!bus.dWEN) bus.dload = bus.ram_load;
                end
            end

            default: ;
        endcase
    end

endmodule
